sobel_hls_mul_pipe: RTL and testbench

//  Parametrised, pipelined integer multiplier for the Sobel datapath (gradient weighting, magnitude scaling).

---
 rtl/sobel_hls_mul_pkg.sv | 34 +++
 rtl/sobel_hls_mul_stage.sv | 24 ++
 rtl/sobel_hls_mul_pipe.sv | 112 +++++++++++
 tb/tb_sobel_hls_mul_pipe.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_hls_mul_pkg.sv
// rtl/sobel_hls_mul_pkg.sv - mode constants, range helpers and overflow check for the Sobel multiplier
package sobel_hls_mul_pkg;

   localparam logic MUL_MODE_UNSIGNED = 1'b0;
   localparam logic MUL_MODE_SIGNED   = 1'b1;

   // Wide enough for any product this block is configured for (DIN0_WIDTH+DIN1_WIDTH < 64).
   localparam int WIDE_W = 64;
   typedef logic signed [WIDE_W-1:0] wide_t;

   function automatic wide_t smax(input int w);
      return (wide_t'(1) <<< (w - 1)) - wide_t'(1);
   endfunction

   function automatic wide_t smin(input int w);
      return -(wide_t'(1) <<< (w - 1));
   endfunction

   function automatic wide_t umax(input int w);
      return (wide_t'(1) <<< w) - wide_t'(1);
   endfunction

   function automatic wide_t umin();
      return '0;
   endfunction

   function automatic logic ovf_check(input wide_t p, input logic mode, input int w);
      if (mode == MUL_MODE_SIGNED)
         return (p > smax(w)) || (p < smin(w));
      else
         return (p < umin()) || (p > umax(w));
   endfunction

endpackage

// File: rtl/sobel_hls_mul_stage.sv
// rtl/sobel_hls_mul_stage.sv - one valid+payload register slice of the multiplier pipeline
module sobel_hls_mul_stage #(
   parameter int W = 21
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         src_valid,
   input  logic [W-1:0] src_data,
   output logic         valid,
   output logic [W-1:0] data
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= 1'b0;
         data  <= '0;
      end else if (load) begin
         valid <= src_valid;
         data  <= src_data;
      end
   end

endmodule

// File: rtl/sobel_hls_mul_pipe.sv
// rtl/sobel_hls_mul_pipe.sv - pipelined signed/unsigned multiplier with valid/ready and overflow flag
// Optional saturation on overflow: define SOBEL_MUL_SAT_EN (default build wraps/truncates).
module sobel_hls_mul_pipe #(
   parameter int DIN0_WIDTH = 9,
   parameter int DIN1_WIDTH = 11,
   parameter int DOUT_WIDTH = 19,
   parameter int NUM_STAGE  = 3
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_signed,
   input  logic [DIN0_WIDTH-1:0] din0,
   input  logic [DIN1_WIDTH-1:0] din1,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DOUT_WIDTH-1:0] dout,
   output logic                  out_ovf
);
   import sobel_hls_mul_pkg::*;

   localparam int P_W  = DIN0_WIDTH + DIN1_WIDTH;
   localparam int PL_W = P_W + 1;
   localparam int LAST = NUM_STAGE - 1;

   // Low P_W bits of the modular product are the exact product in both modes.
   logic           sx0, sx1;
   logic [P_W-1:0] op0, op1, prod;

   assign sx0  = in_signed & din0[DIN0_WIDTH-1];
   assign sx1  = in_signed & din1[DIN1_WIDTH-1];
   assign op0  = {{(P_W-DIN0_WIDTH){sx0}}, din0};
   assign op1  = {{(P_W-DIN1_WIDTH){sx1}}, din1};
   assign prod = op0 * op1;

   logic [NUM_STAGE-1:0] stage_valid;
   logic [NUM_STAGE-1:0] stage_load;
   logic [PL_W-1:0]      stage_data [NUM_STAGE];

   genvar k;
   generate
      for (k = 0; k < NUM_STAGE; k++) begin : g_stage
         // A stage can load unless it and every stage downstream of it is full and stalled.
         assign stage_load[k] = out_ready || !(&stage_valid[LAST:k]);
         if (k == 0) begin : g_first
            sobel_hls_mul_stage #(.W(PL_W)) u_stage (
               .clk       (ap_clk),
               .rst       (ap_rst),
               .load      (stage_load[0]),
               .src_valid (in_valid),
               .src_data  ({in_signed, prod}),
               .valid     (stage_valid[0]),
               .data      (stage_data[0])
            );
         end else begin : g_next
            sobel_hls_mul_stage #(.W(PL_W)) u_stage (
               .clk       (ap_clk),
               .rst       (ap_rst),
               .load      (stage_load[k]),
               .src_valid (stage_valid[k-1]),
               .src_data  (stage_data[k-1]),
               .valid     (stage_valid[k]),
               .data      (stage_data[k])
            );
         end
      end
   endgenerate

   assign in_ready  = !ap_rst && stage_load[0];
   assign out_valid = stage_valid[LAST];

   logic           out_mode;
   logic [P_W-1:0] p;

   assign {out_mode, p} = stage_data[LAST];

   generate
      if (DOUT_WIDTH >= P_W) begin : g_wide
         logic sx;
         assign sx = out_mode & p[P_W-1];
         always_comb begin
            dout = '0;
            for (int i = 0; i < P_W; i++) dout[i] = p[i];
            for (int i = P_W; i < DOUT_WIDTH; i++) dout[i] = sx;
         end
         assign out_ovf = 1'b0;
      end else begin : g_narrow
         wide_t p_wide;
         logic  ovf;
         assign p_wide = (out_mode == MUL_MODE_SIGNED) ?
                         wide_t'({{(WIDE_W-P_W){p[P_W-1]}}, p}) :
                         wide_t'({{(WIDE_W-P_W){1'b0}}, p});
         assign ovf     = ovf_check(p_wide, out_mode, DOUT_WIDTH);
         assign out_ovf = ovf;
`ifdef SOBEL_MUL_SAT_EN
         wide_t lim;
         always_comb begin
            lim = '0;
            if (out_mode == MUL_MODE_SIGNED)
               lim = (p_wide < 0) ? smin(DOUT_WIDTH) : smax(DOUT_WIDTH);
            else
               lim = (p_wide < 0) ? umin() : umax(DOUT_WIDTH);
         end
         assign dout = ovf ? lim[DOUT_WIDTH-1:0] : p[DOUT_WIDTH-1:0];
`else
         assign dout = p[DOUT_WIDTH-1:0];
`endif
      end
   endgenerate

endmodule

// File: tb/tb_sobel_hls_mul_pipe.sv
// tb/tb_sobel_hls_mul_pipe.sv - self-checking bench for sobel_hls_mul_pipe (vectors + scoreboard)
module tb_sobel_hls_mul_pipe;

   localparam int D0 = 9;
   localparam int D1 = 11;
   localparam int DO = 19;
   localparam int NS = 3;

   logic          ap_clk = 1'b0;
   logic          ap_rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_signed = 1'b0;
   logic [D0-1:0] din0 = '0;
   logic [D1-1:0] din1 = '0;
   logic          in_ready, out_valid, out_ovf, out_ready;
   logic [DO-1:0] dout;

   logic [1:0]    rmode = 2'd1;
   logic          rnd_bit = 1'b1;

   assign out_ready = (rmode == 2'd2) ? rnd_bit : rmode[0];

   sobel_hls_mul_pipe #(
      .DIN0_WIDTH(D0), .DIN1_WIDTH(D1), .DOUT_WIDTH(DO), .NUM_STAGE(NS)
   ) dut (
      .ap_clk(ap_clk), .ap_rst(ap_rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_signed(in_signed), .din0(din0), .din1(din1), .out_valid(out_valid),
      .out_ready(out_ready), .dout(dout), .out_ovf(out_ovf)
   );

   always #5 ap_clk = ~ap_clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always @(posedge ap_clk) cyc <= cyc + 1;
   always @(posedge ap_clk) begin
      #1;
      rnd_bit = ($urandom_range(0, 3) != 0);
   end

   typedef struct {
      logic [DO-1:0] d;
      logic          o;
      int            acc;
      bit            lat;
   } exp_t;
   exp_t sb[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   function automatic void model(input logic s, input logic [D0-1:0] a, input logic [D1-1:0] b,
                                 output logic [DO-1:0] d, output logic o);
      longint pa, pb, p, lo, hi, v;
      pa = s ? longint'($signed(a)) : longint'(a);
      pb = s ? longint'($signed(b)) : longint'(b);
      p  = pa * pb;
      lo = s ? -(longint'(1) << (DO - 1)) : 0;
      hi = s ? (longint'(1) << (DO - 1)) - 1 : (longint'(1) << DO) - 1;
      o  = (p < lo) || (p > hi);
      v  = p;
`ifdef SOBEL_MUL_SAT_EN
      if (p < lo) v = lo;
      else if (p > hi) v = hi;
`endif
      d = v[DO-1:0];
   endfunction

   // Output monitor: pops the scoreboard on each transfer and checks hold under stall.
   logic          stalled_prev = 1'b0;
   logic [DO-1:0] held_d;
   logic          held_o;
   always @(negedge ap_clk) begin
      exp_t e;
      if (stalled_prev && !ap_rst) begin
         check("hold_valid", out_valid, 1);
         check("hold_dout", dout, held_d);
         check("hold_ovf", out_ovf, held_o);
      end
      stalled_prev = out_valid && !out_ready && !ap_rst;
      held_d = dout;
      held_o = out_ovf;
      if (!ap_rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: got beat dout=%0h, expected none", dout);
         end else begin
            e = sb.pop_front();
            check("dout", dout, e.d);
            check("ovf", out_ovf, e.o);
            if (e.lat) check("latency", cyc - e.acc, NS);
         end
      end
   end

   task automatic send(input logic s, input logic [D0-1:0] a, input logic [D1-1:0] b,
                       input logic [DO-1:0] ed, input logic eo, input bit lat, input bit must_ready);
      int w;
      exp_t e;
      @(posedge ap_clk);
      #1;
      in_valid = 1'b1; in_signed = s; din0 = a; din1 = b;
      w = 0;
      @(negedge ap_clk);
      while (!in_ready && w < 200) begin
         w++;
         @(negedge ap_clk);
      end
      if (must_ready) check("stream_in_ready", w, 0);
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: got in_ready=0, expected 1");
      end else begin
         e.d = ed; e.o = eo; e.acc = cyc; e.lat = lat;
         sb.push_back(e);
      end
   endtask

   task automatic send_model(input logic s, input logic [D0-1:0] a, input logic [D1-1:0] b,
                             input bit lat, input bit must_ready);
      logic [DO-1:0] d;
      logic          o;
      model(s, a, b, d, o);
      send(s, a, b, d, o, lat, must_ready);
   endtask

   task automatic idle();
      @(posedge ap_clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int w;
      w = 0;
      while (sb.size() != 0 && w < 500) begin
         w++;
         @(negedge ap_clk);
      end
      check("drain_empty", sb.size(), 0);
   endtask

   typedef struct {
      logic          s;
      logic [D0-1:0] a;
      logic [D1-1:0] b;
      logic [DO-1:0] d;
      logic          o;
   } vec_t;
   vec_t vt[9];

`ifdef SOBEL_MUL_SAT_EN
   localparam logic [DO-1:0] E_UMAX = 19'h7FFFF;
   localparam logic [DO-1:0] E_SPOS = 19'h3FFFF;
   localparam logic [DO-1:0] E_U257 = 19'h7FFFF;
`else
   localparam logic [DO-1:0] E_UMAX = 19'h7F601;
   localparam logic [DO-1:0] E_SPOS = 19'h40000;
   localparam logic [DO-1:0] E_U257 = 19'h006FF;
`endif

   initial begin
      #2000000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [D0-1:0] ba [8];
      logic [D1-1:0] bb [8];
      logic          bs [8];
      logic [DO-1:0] d;
      logic          o;
      int            acc;

      vt[0] = '{1'b0, 9'h1FF, 11'h7FF, E_UMAX,    1'b1};
      vt[1] = '{1'b1, 9'h1FF, 11'h002, 19'h7FFFE, 1'b0};
      vt[2] = '{1'b0, 9'h1FF, 11'h002, 19'd1022,  1'b0};
      vt[3] = '{1'b1, 9'h100, 11'h400, E_SPOS,    1'b1};
      vt[4] = '{1'b1, 9'h0FF, 11'h400, 19'h40400, 1'b0};
      vt[5] = '{1'b0, 9'h000, 11'h7FF, 19'h00000, 1'b0};
      vt[6] = '{1'b0, 9'h100, 11'h7FF, 19'h7FF00, 1'b0};
      vt[7] = '{1'b0, 9'h101, 11'h7FF, E_U257,    1'b1};
      vt[8] = '{1'b1, 9'h100, 11'h401, 19'h3FF00, 1'b0};

      #1;
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_dout", dout, 0);
      check("rst_ovf", out_ovf, 0);
      repeat (3) @(posedge ap_clk);
      @(negedge ap_clk);
      ap_rst = 1'b0;
      #1;
      check("rel_in_ready", in_ready, 1);

      for (int i = 0; i < 9; i++) send(vt[i].s, vt[i].a, vt[i].b, vt[i].d, vt[i].o, 1'b0, 1'b0);
      idle();
      drain();

      for (int i = 0; i < 8; i++)
         send_model(1'($urandom_range(0, 1)), D0'($urandom), D1'($urandom), 1'b1, 1'b1);
      idle();
      drain();

      // Backpressure: exactly NS beats buffer, then in_ready drops until out_ready returns.
      for (int i = 0; i < 8; i++) begin
         ba[i] = D0'($urandom); bb[i] = D1'($urandom); bs[i] = 1'($urandom_range(0, 1));
      end
      @(posedge ap_clk);
      #1;
      rmode = 2'd0;
      acc = 0;
      in_valid = 1'b1; in_signed = bs[0]; din0 = ba[0]; din1 = bb[0];
      for (int c = 0; c < 6; c++) begin
         @(negedge ap_clk);
         if (in_ready) begin
            model(bs[acc], ba[acc], bb[acc], d, o);
            sb.push_back('{d, o, cyc, 1'b0});
            acc++;
         end
         @(posedge ap_clk);
         #1;
         in_signed = bs[acc]; din0 = ba[acc]; din1 = bb[acc];
      end
      check("bp_accepted", acc, NS);
      check("bp_in_ready_low", in_ready, 0);
      rmode = 2'd1;
      #1;
      check("bp_in_ready_same_cycle", in_ready, 1);
      @(negedge ap_clk);
      if (in_ready) begin
         model(bs[acc], ba[acc], bb[acc], d, o);
         sb.push_back('{d, o, cyc, 1'b0});
      end
      idle();
      drain();

      @(posedge ap_clk);
      #1;
      rmode = 2'd0;
      send_model(1'b1, 9'h1FF, 11'h003, 1'b0, 1'b0);
      idle();
      for (int c = 0; c < 4; c++) begin
         @(negedge ap_clk);
         check("single_no_block", in_ready, 1);
      end
      @(posedge ap_clk);
      #1;
      rmode = 2'd1;
      drain();

      // Reset with beats in flight.
      @(posedge ap_clk);
      #1;
      rmode = 2'd0;
      send_model(1'b0, 9'h055, 11'h123, 1'b0, 1'b0);
      send_model(1'b1, 9'h1AA, 11'h321, 1'b0, 1'b0);
      idle();
      repeat (4) @(negedge ap_clk);
      check("pre_rst_out_valid", out_valid, 1);
      #2;
      ap_rst = 1'b1;
      #1;
      check("async_rst_out_valid", out_valid, 0);
      check("async_rst_in_ready", in_ready, 0);
      check("async_rst_dout", dout, 0);
      sb.delete();
      repeat (2) @(posedge ap_clk);
      @(negedge ap_clk);
      ap_rst = 1'b0;
      rmode = 2'd1;
      for (int c = 0; c < 6; c++) begin
         @(negedge ap_clk);
         check("no_out_after_rst", out_valid, 0);
      end

      rmode = 2'd2;
      for (int i = 0; i < 40; i++) begin
         send_model(1'($urandom_range(0, 1)), D0'($urandom), D1'($urandom), 1'b0, 1'b0);
         if ($urandom_range(0, 3) == 0) idle();
      end
      idle();
      rmode = 2'd1;
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
